bpsk_demodulator: RTL and testbench
===================================

// Module: bpsk_demodulator
// PURPOSE
//  Coherent BPSK receiver stage; sits directly downstream of bpsk_modulator.
//  Consumes its carrier samples, correlates each symbol against a local reference
//  sine (multiply-accumulate over one carrier period), slices the sign into a bit
//  and packs the bits into DATA_WIDTH-bit words. Assumes the carrier is phase-aligned
//  with the first en sample after reset. No carrier or timing recovery.
// PARAMETERS
//  SINE_WIDTH  12   sample width; offset-binary, midpoint 2**(SINE_WIDTH-1)
//  DATA_WIDTH  8    bits per output word
//  SPS         256  samples per symbol (= one carrier period = LUT depth); power of 2
// PORTS
//  clk         in   1           single clock, rising edge
//  arst        in   1           reset, synchronous, active-high
//  en          in   1           sample valid; in_sample is taken on clk when en=1
//  in_sample   in   SINE_WIDTH  carrier sample (modulator signal_out format)
//  bit_out     out  1           sliced bit; 0 = in-phase, 1 = inverted
//  bit_valid   out  1           1-cycle strobe qualifying bit_out
//  out_data    out  DATA_WIDTH  assembled word, first received bit in MSB
//  out_valid   out  1           1-cycle strobe qualifying out_data
// BEHAVIOUR
//  Reset (arst=1 at a clk edge): phase_cnt, bit_cnt, accumulator, pipeline valids,
//   shift register cleared. bit_out=0, bit_valid=0, out_data=0, out_valid=0.
//   arst takes priority over en. Mid-symbol reset discards the partial symbol/word.
//  Phase: phase_cnt (log2(SPS) bits) advances only on en; wraps SPS-1 -> 0.
//   Symbol boundary = en sample with phase_cnt == SPS-1.
//  Pipeline, advanced every clk, each stage with its own valid bit (not stalled by en):
//   S1 (edge of en cycle N): s = in_sample - midpoint (signed SINE_WIDTH+1),
//       r = ref_lut[phase_cnt] - midpoint; last flag captured.
//   S2 (N+1): p = s*r, signed 2*(SINE_WIDTH+1) bits.
//   S3 (N+2): acc += p; when last, the final sum goes to the slicer and acc
//       restarts at 0 so the next symbol's first product is not lost.
//   S4 (N+3): bit_out = acc_final < 0; bit_valid pulses for one cycle.
//  Latency: en cycle of last sample -> bit_valid is 3 clk edges later.
//  Accumulator width 2*(SINE_WIDTH+1)+log2(SPS)+1; cannot overflow; no saturation.
//  Slicer tie: acc_final == 0 -> bit 0.
//  Packing: on bit_valid, shreg = {shreg[DATA_WIDTH-2:0], bit}; bit_cnt++.
//   Same edge as the DATA_WIDTH-th bit: out_data <= completed word, out_valid=1 for
//   one cycle, bit_cnt wraps to 0. out_data holds its value until the next word.
//  en low mid-symbol: phase_cnt and acc hold; samples already in flight complete;
//   no bit is emitted until the symbol's remaining samples arrive.
//  en gaps of any length between samples are legal; back-to-back en=1 gives full rate.
// STRUCTURE
//  Include bpsk_pkg.vh (shared with bpsk_modulator): SINE_WIDTH/SPS defaults,
//   MIDPOINT, bit polarity (PHASE_0=0, PHASE_180=1), LUT init file name.
//  One sub-module: sine_rom (SPS x SINE_WIDTH, registered read, address = phase_cnt),
//   the same ROM the modulator uses; its read register is S1's r path.
//  Top level: phase counter, MAC pipeline, slicer, packer.
// TESTING
//  1 arst=1 for 2 clk with en=1 and in_sample driven -> all outputs 0, no strobes.
//  2 Loopback: bpsk_modulator -> demod, data 8'hA5, en held 1 -> out_valid once,
//    out_data=8'hA5, first bit_valid 3 clk after the 256th accepted sample.
//  3 Constant in_sample=12'h800 (midpoint) for 256 samples -> acc=0, bit_out=0.
//  4 Loopback 8'h3C with en toggled by a random pattern (~50% duty) -> out_data=8'h3C,
//    bit_valid count 8, no extra strobes during en gaps.
//  5 arst pulsed after 100 samples of symbol 3, then fresh 8'hC3 -> out_data=8'hC3,
//    no word built from the discarded partial bits.
//  6 Two words 8'hFF then 8'h00 back-to-back -> out_valid exactly 2048 sample-cycles
//    apart, outputs FF then 00; bits 7->0 boundary shows no lost sample.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared BPSK constants and the integer sine used to fill the carrier ROM.
// The same table feeds the modulator, so the receiver correlates against the transmitted shape.
package bpsk_pkg;

  localparam int SINE_WIDTH_DEF = 12;
  localparam int SPS_DEF        = 256;
  localparam logic PHASE_0      = 1'b0;
  localparam logic PHASE_180    = 1'b1;

  // Bhaskara-style rational sine approximation; integer-only, so it folds to constants.
  function automatic longint sine_value(input longint phase, input longint sps, input longint amp);
    longint half;
    longint u;
    longint t;
    longint v;
    half = sps / 64'sd2;
    u    = phase % half;
    t    = u * (half - u);
    v    = (amp * 64'sd16 * t) / (64'sd5 * half * half - 64'sd4 * t);
    if (phase < half) begin
      return v;
    end else begin
      return -v;
    end
  endfunction

endpackage

// File: rtl/bpsk_sine_rom.sv
// One carrier period of offset-binary sine samples with a registered read port.
module sine_rom
  import bpsk_pkg::*;
#(
  parameter int SINE_WIDTH = SINE_WIDTH_DEF,
  parameter int SPS        = SPS_DEF
) (
  input  logic                   clk,
  input  logic [$clog2(SPS)-1:0] addr,
  output logic [SINE_WIDTH-1:0]  rd_data
);

  localparam longint MID = longint'(1) << (SINE_WIDTH - 1);

  logic [SINE_WIDTH-1:0] table_s [SPS];
  logic [SINE_WIDTH-1:0] rd_data_d;
  logic [SINE_WIDTH-1:0] rd_data_q;

  for (genvar i = 0; i < SPS; i++) begin : g_table
    assign table_s[i] = SINE_WIDTH'(MID + sine_value(longint'(i), longint'(SPS), MID - 64'sd1));
  end

  // Table lookup for the next read.
  always_comb begin
    rd_data_d = table_s[addr];
  end

  // Read register.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK receiver: per-symbol multiply-accumulate against the reference sine,
// sign slicer and MSB-first word packer. Carrier phase is assumed aligned at reset.
module bpsk_demodulator
  import bpsk_pkg::*;
#(
  parameter int SINE_WIDTH = SINE_WIDTH_DEF,
  parameter int DATA_WIDTH = 8,
  parameter int SPS        = SPS_DEF
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  input  logic [SINE_WIDTH-1:0] in_sample,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  localparam int PW = $clog2(SPS);
  localparam int SW = SINE_WIDTH + 1;
  localparam int MW = 2 * SW;
  localparam int AW = MW + PW + 1;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [SW-1:0]        MID_S     = SW'(1 << (SINE_WIDTH - 1));
  localparam logic [PW-1:0]        PHASE_INC = PW'(1);
  localparam logic [PW-1:0]        PHASE_END = PW'(SPS - 1);
  localparam logic [CW-1:0]        CNT_INC   = CW'(1);
  localparam logic [CW-1:0]        LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic signed [AW-1:0] ACC_ZERO  = '0;

  logic [PW-1:0]           phase_cnt_d, phase_cnt_q;
  logic                    s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
  logic signed [SW-1:0]    s1_s_d, s1_s_q, r_s;
  logic [SINE_WIDTH-1:0]   rom_data;
  logic                    s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
  logic signed [MW-1:0]    s2_p_d, s2_p_q;
  logic signed [AW-1:0]    acc_d, acc_q, acc_sum_s, fin_acc_d, fin_acc_q;
  logic                    fin_valid_d, fin_valid_q;
  logic                    bit_out_d, bit_out_q, bit_valid_d, bit_valid_q;
  logic [DATA_WIDTH-2:0]   shreg_d, shreg_q;
  logic [DATA_WIDTH-1:0]   word_s, out_data_d, out_data_q;
  logic [CW-1:0]           bit_cnt_d, bit_cnt_q;
  logic                    out_valid_d, out_valid_q;

  // The ROM read register is the reference half of the first pipeline stage.
  sine_rom #(
    .SINE_WIDTH(SINE_WIDTH),
    .SPS       (SPS)
  ) u_sine_rom (
    .clk    (clk),
    .addr   (phase_cnt_q),
    .rd_data(rom_data)
  );

  assign r_s = $signed({1'b0, rom_data[SINE_WIDTH-1:0]} - MID_S);

  // Phase tracking and sample capture; only accepted samples move the phase.
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    s1_s_d      = s1_s_q;
    if (en) begin
      phase_cnt_d = phase_cnt_q + PHASE_INC;
      s1_s_d      = $signed({1'b0, in_sample} - MID_S);
    end else begin
      phase_cnt_d = phase_cnt_q;
      s1_s_d      = s1_s_q;
    end
    s1_valid_d = en;
    s1_last_d  = en & (phase_cnt_q == PHASE_END);
  end

  // Product stage and accumulator; the closing sum restarts the accumulator at zero.
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_last_d   = s1_last_q;
    s2_p_d      = MW'(s1_s_q) * MW'(r_s);
    acc_sum_s   = acc_q + AW'(s2_p_q);
    acc_d       = acc_q;
    fin_acc_d   = fin_acc_q;
    fin_valid_d = 1'b0;
    if (s2_valid_q && s2_last_q) begin
      acc_d       = ACC_ZERO;
      fin_acc_d   = acc_sum_s;
      fin_valid_d = 1'b1;
    end else if (s2_valid_q) begin
      acc_d = acc_sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Slicer (zero resolves to the in-phase bit) and MSB-first packer.
  always_comb begin
    bit_out_d   = bit_out_q;
    bit_valid_d = fin_valid_q;
    if (fin_valid_q) begin
      bit_out_d = (fin_acc_q < ACC_ZERO) ? PHASE_180 : PHASE_0;
    end else begin
      bit_out_d = bit_out_q;
    end
    word_s      = {shreg_q, bit_out_d};
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (fin_valid_q) begin
      shreg_d = word_s[DATA_WIDTH-2:0];
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d   = '0;
        out_data_d  = word_s;
        out_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_INC;
      end
    end else begin
      shreg_d = shreg_q;
    end
  end

  // State registers with synchronous reset taking priority over en.
  always_ff @(posedge clk) begin
    if (arst) begin
      phase_cnt_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_s_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_p_q      <= '0;
      acc_q       <= '0;
      fin_acc_q   <= '0;
      fin_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_s_q      <= s1_s_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_p_q      <= s2_p_d;
      acc_q       <= acc_d;
      fin_acc_q   <= fin_acc_d;
      fin_valid_q <= fin_valid_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench: an ideal floating-point BPSK modulator drives the demodulator,
// and a monitor logs every strobe with its cycle number for the checks.
module tb_bpsk_demodulator;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] in_sample = 12'h000;
  logic        bit_out;
  logic        bit_valid;
  logic [7:0]  out_data;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int sym0_cyc = 0;

  logic [7:0] words[$];
  int         ov_cyc[$];
  int         bv_cyc[$];
  logic       bv_bits[$];

  bpsk_demodulator #(
    .SINE_WIDTH(12),
    .DATA_WIDTH(8),
    .SPS       (256)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .en       (en),
    .in_sample(in_sample),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe logger, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bit_valid) begin
      bv_cyc.push_back(cyc);
      bv_bits.push_back(bit_out);
    end
    if (out_valid) begin
      words.push_back(out_data);
      ov_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mod_sample(input logic b, input int ph);
    real x;
    int  s;
    x = 2047.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 256.0);
    s = int'(x);
    return b ? 12'(2048 - s) : 12'(2048 + s);
  endfunction

  task automatic step(input logic e, input logic [11:0] v);
    @(negedge clk);
    en = e;
    in_sample = v;
    @(posedge clk);
    #1;
    if (e) acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'($urandom_range(0, 4095)));
  endtask

  task automatic send_symbol(input logic b, input int nsamp, input logic gappy);
    for (int ph = 0; ph < nsamp; ph++) begin
      if (gappy) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) step(1'b0, 12'($urandom_range(0, 4095)));
      end
      step(1'b1, mod_sample(b, ph));
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic gappy);
    for (int k = 7; k >= 0; k--) begin
      send_symbol(w[k], 256, gappy);
      if (k == 7) sym0_cyc = acc_cyc;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    en = 1'b0;
    arst = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    int w0;
    int b0;

    // Reset held with en active: nothing may leave the block.
    @(negedge clk);
    arst = 1'b1;
    en = 1'b1;
    in_sample = 12'hABC;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_bit_out", 64'(bit_out), 64'd0);
      check_eq("rst_bit_valid", 64'(bit_valid), 64'd0);
      check_eq("rst_out_data", 64'(out_data), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    arst = 1'b0;
    en = 1'b0;
    idle(2);

    // Full-rate loopback of A5 with latency of the first bit.
    w0 = words.size();
    b0 = bv_cyc.size();
    send_word(8'hA5, 1'b0);
    idle(6);
    check_eq("a5_word_count", 64'(words.size() - w0), 64'd1);
    if (words.size() > w0) check_eq("a5_word", 64'(words[w0]), 64'hA5);
    check_eq("a5_bit_count", 64'(bv_cyc.size() - b0), 64'd8);
    if (bv_cyc.size() > b0) check_eq("a5_latency", 64'(bv_cyc[b0] - sym0_cyc), 64'd3);

    // Midpoint input correlates to exactly zero, which slices to 0.
    b0 = bv_cyc.size();
    for (int i = 0; i < 256; i++) step(1'b1, 12'h800);
    idle(6);
    check_eq("mid_bit_count", 64'(bv_cyc.size() - b0), 64'd1);
    if (bv_bits.size() > b0) check_eq("mid_bit", 64'(bv_bits[b0]), 64'd0);
    pulse_reset();
    idle(2);

    // Randomly gapped en with junk samples in the gaps.
    w0 = words.size();
    b0 = bv_cyc.size();
    send_word(8'h3C, 1'b1);
    idle(6);
    check_eq("3c_word_count", 64'(words.size() - w0), 64'd1);
    if (words.size() > w0) check_eq("3c_word", 64'(words[w0]), 64'h3C);
    check_eq("3c_bit_count", 64'(bv_cyc.size() - b0), 64'd8);

    // Partial word abandoned by a mid-symbol reset.
    w0 = words.size();
    b0 = bv_cyc.size();
    send_symbol(1'b0, 256, 1'b0);
    send_symbol(1'b1, 256, 1'b0);
    send_symbol(1'b0, 256, 1'b0);
    send_symbol(1'b1, 100, 1'b0);
    pulse_reset();
    check_eq("partial_bits", 64'(bv_cyc.size() - b0), 64'd3);
    idle(2);
    send_word(8'hC3, 1'b0);
    idle(6);
    check_eq("c3_word_count", 64'(words.size() - w0), 64'd1);
    if (words.size() > w0) check_eq("c3_word", 64'(words[w0]), 64'hC3);

    // Two back-to-back words, spaced by exactly 2048 accepted samples.
    w0 = words.size();
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    idle(6);
    check_eq("b2b_word_count", 64'(words.size() - w0), 64'd2);
    if (words.size() > w0 + 1) begin
      check_eq("b2b_first", 64'(words[w0]), 64'hFF);
      check_eq("b2b_second", 64'(words[w0 + 1]), 64'h00);
      check_eq("b2b_spacing", 64'(ov_cyc[w0 + 1] - ov_cyc[w0]), 64'd2048);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
